// File: rtl/serial_addsub_if.sv
// serial_addsub_if: request/result bundle for serial_addsub.
// master issues start/modo/operands, slave returns status and result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             enb;
  logic             start;
  logic [1:0]       modo;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic             OVF;

  modport master (
    output enb, start, modo, A, B,
    input  busy, done, Q, RCO, OVF
  );

  modport slave (
    input  enb, start, modo, A, B,
    output busy, done, Q, RCO, OVF
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: SLICE-bit-per-cycle add/sub, LSB first,
// start/busy/done handshake, carry/borrow and signed overflow.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int K  = WIDTH / SLICE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $fatal(1, "serial_addsub: SLICE must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sub_q, sub_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             cy_q, cy_d;
  logic             rco_q, rco_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] s_s;
  logic [SLICE:0]   ext;
  logic [WIDTH-1:0] res;
  logic             cin;
  logic             cout;
  logic             nxt_cy;
  logic             last;

  // Slice adder: subtract is A + ~B + 1, borrow kept as inverted carry.
  always_comb begin
    a_s    = a_q[SLICE-1:0];
    b_s    = sub_q ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
    cin    = sub_q ? ~cy_q : cy_q;
    ext    = {1'b0, a_s} + {1'b0, b_s}
           + {{SLICE{1'b0}}, cin};
    s_s    = ext[SLICE-1:0];
    cout   = ext[SLICE];
    nxt_cy = sub_q ? ~cout : cout;
    res    = (acc_q >> SLICE)
           | (WIDTH'(s_s) << (WIDTH - SLICE));
    last   = (cnt_q == CW'(K - 1));
  end

  // Next-state and datapath control; enb=0 holds everything.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    cy_d    = cy_q;
    rco_d   = rco_q;
    ovf_d   = ovf_q;
    if (bus.enb) begin
      unique case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (bus.start) begin
            unique case (bus.modo)
              2'b01, 2'b10: begin
                a_d     = bus.A;
                b_d     = bus.B;
                amsb_d  = bus.A[WIDTH-1];
                bmsb_d  = bus.B[WIDTH-1];
                sub_d   = bus.modo[1];
                cnt_d   = '0;
                cy_d    = 1'b0;
                acc_d   = '0;
                state_d = RUN;
              end
              2'b11: begin
                q_d     = '0;
                rco_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = DONE;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          a_d   = a_q >> SLICE;
          b_d   = b_q >> SLICE;
          acc_d = res;
          cy_d  = nxt_cy;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            q_d   = res;
            rco_d = nxt_cy;
            if (sub_q)
              ovf_d = (amsb_q != bmsb_q)
                    & (s_s[SLICE-1] != amsb_q);
            else
              ovf_d = (amsb_q == bmsb_q)
                    & (s_s[SLICE-1] != amsb_q);
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      cy_q    <= 1'b0;
      rco_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      cy_q    <= cy_d;
      rco_q   <= rco_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.Q    = q_q;
  assign bus.RCO  = rco_q;
  assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: random + directed stimulus, queue scoreboard
// against an integer-arithmetic reference model.
module tb_serial_addsub;
  localparam int W = 8;
  localparam int S = 2;
  localparam int K = W / S;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W), .SLICE(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] q;
    logic       rco;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   en_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a,
                                 input logic [7:0] b,
                                 input logic [1:0] m);
    exp_t e;
    int ua, ub, sa, sbv, r, sr;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    e.q = 8'h00;
    e.rco = 1'b0;
    e.ovf = 1'b0;
    e.cyc = 0;
    if (m == 2'b01) begin
      r     = ua + ub;
      sr    = sa + sbv;
      e.q   = r[7:0];
      e.rco = (r > 255);
      e.ovf = (sr > 127) || (sr < -128);
    end else if (m == 2'b10) begin
      r     = ua - ub;
      sr    = sa - sbv;
      e.q   = r[7:0];
      e.rco = (ua < ub);
      e.ovf = (sr > 127) || (sr < -128);
    end
    return e;
  endfunction

  // Monitor: one pop per enabled cycle spent in DONE.
  always @(negedge clk) begin
    if (rst_n && bus.done && en_seen) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("Q", 32'(bus.Q), 32'(mon_e.q));
        chk("RCO", 32'(bus.RCO), 32'(mon_e.rco));
        chk("OVF", 32'(bus.OVF), 32'(mon_e.ovf));
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
    en_seen = bus.enb;
  end

  task automatic op(input logic [7:0] a,
                    input logic [7:0] b,
                    input logic [1:0] m,
                    input int stall,
                    input bit poke,
                    input bit b2b);
    exp_t e;
    int   t0, bcnt;
    bit   got;
    bus.enb   = 1'b1;
    bus.start = 1'b1;
    bus.modo  = m;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    t0        = cyc;
    bus.start = 1'b0;
    bus.modo  = 2'($urandom);
    bus.A     = 8'($urandom);
    bus.B     = 8'($urandom);
    if (m == 2'b01 || m == 2'b10) begin
      e     = model(a, b, m);
      e.cyc = t0 + K + stall;
      sb.push_back(e);
      got  = 1'b0;
      bcnt = 0;
      for (int i = 0; i < 40; i++) begin
        if (bus.done) begin
          got = 1'b1;
          break;
        end
        if (bus.busy) bcnt++;
        if (i == 1 && poke) begin
          bus.start = 1'b1;
          bus.modo  = 2'b01;
          bus.A     = 8'($urandom);
          bus.B     = 8'($urandom);
        end
        if (i == 2) begin
          bus.start = 1'b0;
          if (stall > 0) bus.enb = 1'b0;
        end
        if (stall > 0 && i == 2 + stall)
          bus.enb = 1'b1;
        @(posedge clk); #1;
      end
      chk("done_seen", 32'(got), 32'd1);
      chk("busy_cycles", 32'(bcnt), 32'(K + stall));
    end else if (m == 2'b11) begin
      e     = model(a, b, m);
      e.cyc = t0;
      sb.push_back(e);
      chk("clr_busy", 32'(bus.busy), 32'd0);
      chk("clr_done", 32'(bus.done), 32'd1);
    end else begin
      chk("nop_busy", 32'(bus.busy), 32'd0);
      repeat (5) begin
        @(posedge clk); #1;
      end
      chk("nop_done", 32'(bus.done), 32'd0);
    end
    if (!b2b && m != 2'b00) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.enb   = 1'b0;
    bus.start = 1'b0;
    bus.modo  = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    #12;
    chk("rst_Q", 32'(bus.Q), 32'd0);
    chk("rst_RCO", 32'(bus.RCO), 32'd0);
    chk("rst_OVF", 32'(bus.OVF), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    bus.enb = 1'b1;
    @(posedge clk); #1;

    op(8'hF0, 8'h20, 2'b01, 0, 0, 0);
    op(8'h7F, 8'h01, 2'b01, 0, 0, 0);
    op(8'h05, 8'h07, 2'b10, 0, 0, 0);
    op(8'h80, 8'h01, 2'b10, 0, 0, 0);
    op(8'h12, 8'h34, 2'b01, 3, 0, 0);
    op(8'h0A, 8'h0B, 2'b10, 0, 1, 0);
    op(8'h55, 8'h66, 2'b11, 0, 0, 0);
    op(8'h33, 8'h44, 2'b00, 0, 0, 0);
    op(8'h01, 8'h01, 2'b01, 0, 0, 1);
    op(8'h00, 8'h01, 2'b10, 0, 0, 1);

    bus.enb = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("done_hold", 32'(bus.done), 32'd1);
    end
    bus.enb = 1'b1;
    @(posedge clk); #1;
    chk("done_clear", 32'(bus.done), 32'd0);

    bus.start = 1'b1;
    bus.modo  = 2'b01;
    bus.A     = 8'h33;
    bus.B     = 8'h44;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_Q", 32'(bus.Q), 32'd0);
    chk("abort_RCO", 32'(bus.RCO), 32'd0);
    chk("abort_OVF", 32'(bus.OVF), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(bus.done), 32'd0);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 9) < 4 ? 1 :
             $urandom_range(0, 5) < 4 ? 2 :
             $urandom_range(0, 1) ? 3 : 0);
      op(8'($urandom), 8'($urandom), m,
         int'($urandom_range(0, 2)),
         1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)));
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
